// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; din[7:0] queued, serialised LSB first on txd.
// Latency: byte pushed into an empty FIFO while idle starts its start bit one edge later; frames are 10*CLK_DIV cycles.
// Backpressure: none toward the writer; a write while full is dropped and latches the sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLK_DIV = 868,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      din,
  input  logic             we,
  output logic             txd,
  output logic             busy,
  output logic             full,
  output logic [DEPTH:0]   count,
  output logic             overflow
);

  localparam int             ENTRIES   = 1 << DEPTH;
  localparam logic [15:0]    BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [DEPTH:0] CNT_FULL  = (DEPTH + 1)'(ENTRIES);
  localparam logic [DEPTH:0] CNT_ONE   = (DEPTH + 1)'(1);
  localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       mem [ENTRIES];
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             baud_last;
  logic             unused_din;

  // Only the low byte of the core's write word is transmitted.
  assign unused_din = ^din[31:8];

  assign full      = (count == CNT_FULL);
  assign busy      = (state != IDLE) || (count != '0);
  assign baud_last = (baud_cnt == BAUD_LAST);
  // full is the registered value, so a same-edge pop never makes room for a write.
  assign push      = we && !full;
  // Pop either from idle or at the very last stop-bit cycle so frames chain without a gap.
  assign pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_last));

  // FIFO storage: data only, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (we && full) overflow <= 1'b1;
    end
  end

  // Transmit FSM: baud timing, bit sequencing and the registered serial output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Shift so the next bit is always at shreg[1] when it is launched.
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLK_DIV=4, DEPTH=2.
// Accepted bytes are queued on write; a line monitor pops and compares every bit sample.
// Waits are bounded; a watchdog ends the run if anything stalls.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             we    = 1'b0;
  logic [31:0]      din   = '0;
  logic             txd;
  logic             busy;
  logic             full;
  logic             overflow;
  logic [DEPTH:0]   count;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int frames = 0;
  logic [7:0] sb[$];
  int starts[$];

  logic       in_frame = 1'b0;
  int         pos      = 0;
  logic [7:0] cur      = '0;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .we       (we),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Line monitor: a low sample outside a frame is a start bit; the next 39 samples are checked.
  always @(negedge clk) begin
    logic e;
    int   slot;
    if (!reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          cur = 8'h00;
        end else begin
          cur = sb.pop_front();
        end
        starts.push_back(cyc);
        in_frame = 1'b1;
        pos = 0;
      end
    end else begin
      pos++;
      slot = pos / CLK_DIV;
      if (slot == 0)      e = 1'b0;
      else if (slot == 9) e = 1'b1;
      else                e = cur[slot-1];
      chk($sformatf("frame_%02h_sample_%0d", cur, pos), {31'd0, txd}, {31'd0, e});
      if (pos == 10*CLK_DIV - 1) begin
        in_frame = 1'b0;
        frames++;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int n0;
    int peak;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single byte 0x55: latency and frame length
    @(negedge clk);
    we = 1'b1; din = 32'h0000_0055; sb.push_back(8'h55);
    @(negedge clk);
    we = 1'b0;
    chk("t1_count_after_push", {29'd0, count}, 32'd1);
    chk("t1_txd_still_idle", {31'd0, txd}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_count_after_pop", {29'd0, count}, 32'd0);
    chk("t1_txd_start", {31'd0, txd}, 32'd0);
    repeat (39) @(negedge clk);
    chk("t1_busy_last_stop", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_busy_dropped", {31'd0, busy}, 32'd0);
    chk("t1_count_end", {29'd0, count}, 32'd0);
    chk("t1_frames", frames, 32'd1);

    // Upper din bits ignored
    @(negedge clk);
    we = 1'b1; din = 32'hFFFF_FF41; sb.push_back(8'h41);
    @(negedge clk);
    we = 1'b0;
    wait_idle(200);
    chk("t2_frames", frames, 32'd2);

    // Back-to-back frames with no idle gap
    n0 = starts.size();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0 && int'(count) > peak) peak = int'(count);
      we = 1'b1; din = 32'(i + 1); sb.push_back(8'(i + 1));
    end
    @(negedge clk);
    we = 1'b0;
    if (int'(count) > peak) peak = int'(count);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    chk("t3_count_peak", peak, 32'd2);
    wait_idle(400);
    chk("t3_frame_count", starts.size() - n0, 32'd3);
    if (starts.size() - n0 == 3) begin
      chk("t3_gap_1_2", starts[n0+1] - starts[n0], 32'd40);
      chk("t3_gap_2_3", starts[n0+2] - starts[n0+1], 32'd40);
    end

    // Overflow: six consecutive writes, sixth dropped
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("t4_full_before", {31'd0, full}, 32'd1);
        chk("t4_count_before", {29'd0, count}, 32'd4);
        chk("t4_ovf_before", {31'd0, overflow}, 32'd0);
      end
      we = 1'b1; din = 32'h10 + 32'(i);
      if (i < 5) sb.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    we = 1'b0;
    chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
    chk("t4_count_unchanged", {29'd0, count}, 32'd4);
    wait_idle(600);
    chk("t4_frames", frames - f0, 32'd5);
    chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset clears overflow; first edge after release accepts a write
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ovf_cleared", {31'd0, overflow}, 32'd0);
    f0 = frames;
    @(negedge clk);
    reset = 1'b1;
    we = 1'b1; din = 32'h31; sb.push_back(8'h31);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      din = 32'h31 + 32'(i); sb.push_back(8'h31 + 8'(i));
    end
    @(negedge clk);
    we = 1'b0;
    repeat (36) @(negedge clk);
    chk("t5_count_full", {29'd0, count}, 32'd4);
    chk("t5_full", {31'd0, full}, 32'd1);
    // Offer a write on the same edge that the stop bit pops the FIFO
    we = 1'b1; din = 32'hEE;
    @(negedge clk);
    we = 1'b0;
    chk("t5_count_after_pop", {29'd0, count}, 32'd3);
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    chk("t5_not_full", {31'd0, full}, 32'd0);
    wait_idle(800);
    chk("t5_frames", frames - f0, 32'd5);

    // Reset mid-frame during DATA bit 3 of 0xA5 with two bytes queued
    f0 = frames;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      we = 1'b1;
      case (i)
        0:       din = 32'hA5;
        1:       din = 32'h11;
        default: din = 32'h22;
      endcase
      sb.push_back(din[7:0]);
    end
    @(negedge clk);
    we = 1'b0;
    repeat (16) @(negedge clk);
    chk("t6_txd_bit3", {31'd0, txd}, 32'd0);
    chk("t6_count_queued", {29'd0, count}, 32'd2);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("t6_txd_async", {31'd0, txd}, 32'd1);
    chk("t6_count_async", {29'd0, count}, 32'd0);
    chk("t6_busy_async", {31'd0, busy}, 32'd0);
    chk("t6_full_async", {31'd0, full}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("t6_no_frames", frames - f0, 32'd0);
    chk("t6_txd_high", {31'd0, txd}, 32'd1);
    chk("t6_busy_low", {31'd0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
